// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: launches one byte per tx_start and waits for tx_busy to acknowledge and then finish it.
// Latency: a write into an empty FIFO with an idle transmitter gives tx_start two edges later. A write to a full FIFO is dropped and reported on overflow.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_en,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       ack_err,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_VAL  = TW'(ACK_TIMEOUT);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_tx_data;
    logic          r_overflow;
    logic          r_ack_err;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;

    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_pop;
    logic          w_timeout;
    logic [TW-1:0] w_timer_inc;
    logic [1:0]    w_state_nxt;

    // full is taken from the pre-edge count, so a pop in the same edge never frees room for a write
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_wr        = wr_en & ~w_full;
    assign w_pop       = (r_state == S_IDLE) & ~w_empty & ~tx_busy;
    assign w_timer_inc = r_timer + 1'b1;
    assign w_timeout   = (r_state == S_WAIT_ACK) & ~tx_busy & (w_timer_inc == TMO_VAL);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_tx_data  <= 8'h00;
            r_overflow <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + 1'b1;
                r_tx_data <= r_mem[r_rptr];
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= wr_en & w_full;
            r_ack_err  <= w_timeout;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_pop) w_state_nxt = S_LAUNCH;
            S_LAUNCH:    w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_LAUNCH) begin
                r_timer <= '0;
            end else if ((r_state == S_WAIT_ACK) && !tx_busy) begin
                r_timer <= w_timer_inc;
            end
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign ack_err  = r_ack_err;
    assign tx_data  = r_tx_data;
    assign tx_start = (r_state == S_LAUNCH);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based reference model predicts every output each cycle, and directed phases cover the edge cases.
module tb_uart_tx_fifo;
    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 4;
    localparam int CW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          ack_err;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .ack_err(ack_err), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus a note of where the current byte is in its
    // launch/acknowledge life (m_launch = cycles since launch, -1 when none pending).
    logic [7:0] mq[$];
    int         m_launch = -1;
    bit         m_acked  = 1'b0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_ovf    = 1'b0;
    bit         m_aerr   = 1'b0;

    function automatic bit m_idle();
        return (m_launch < 0) && !m_acked;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_launch = -1;
            m_acked  = 1'b0;
            m_byte   = 8'h00;
            m_ovf    = 1'b0;
            m_aerr   = 1'b0;
        end else begin
            bit was_full, was_empty, pop;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            m_ovf  = wr_en && was_full;
            m_aerr = 1'b0;
            pop    = 1'b0;
            if (m_acked) begin
                if (!tx_busy) m_acked = 1'b0;
            end else if (m_launch == 0) begin
                m_launch = 1;
            end else if (m_launch > 0) begin
                if (tx_busy) begin
                    m_launch = -1;
                    m_acked  = 1'b1;
                end else if (m_launch == ACK_TIMEOUT) begin
                    m_launch = -1;
                    m_aerr   = 1'b1;
                end else begin
                    m_launch++;
                end
            end else if (!was_empty && !tx_busy) begin
                pop = 1'b1;
            end
            if (pop) begin
                m_byte   = mq.pop_front();
                m_launch = 0;
            end
            if (wr_en && !was_full) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        chk("count",    32'(count),    32'(mq.size()));
        chk("full",     32'(full),     32'(mq.size() == DEPTH));
        chk("empty",    32'(empty),    32'(mq.size() == 0));
        chk("tx_start", 32'(tx_start), 32'(m_launch == 0));
        chk("tx_data",  32'(tx_data),  32'(m_byte));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("ack_err",  32'(ack_err),  32'(m_aerr));
    end

    // Transmitter stub: 0 tied low, 1 tied high, 2 random, 3 frame-like response to tx_start
    int bmode     = 0;
    int frame_len = 10;
    initial begin
        int st_wait, st_len;
        st_wait = 0;
        st_len  = 0;
        forever begin
            @(negedge clk);
            case (bmode)
                0: tx_busy = 1'b0;
                1: tx_busy = 1'b1;
                2: tx_busy = 1'($urandom_range(0, 1));
                default: begin
                    if (tx_start) begin
                        st_wait = $urandom_range(0, 2);
                        st_len  = frame_len;
                    end
                    if (st_wait > 0) begin
                        st_wait--;
                        tx_busy = 1'b0;
                    end else if (st_len > 0) begin
                        st_len--;
                        tx_busy = 1'b1;
                    end else begin
                        tx_busy = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic put(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (!(m_idle() && mq.size() == 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(m_idle() && mq.size() == 0), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last, gap, pops, starts;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_empty",  32'(empty),   32'd1);
        chk("rst_txdata", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single byte and first-launch latency
        bmode = 3; frame_len = 100;
        put(8'hA5);
        chk("lat_empty",  32'(empty),    32'd0);
        chk("lat_start0", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("lat_start1", 32'(tx_start), 32'd1);
        chk("lat_data",   32'(tx_data),  32'hA5);
        @(negedge clk);
        chk("lat_pulse1", 32'(tx_start), 32'd0);
        wait_idle("single_drain", 300);
        chk("single_cnt0", 32'(count), 32'd0);

        // burst of 16 while the transmitter is held busy, then drain with frame spacing
        bmode = 1;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) put(8'(i));
        chk("burst_full", 32'(full), 32'd1);
        bmode = 3; frame_len = 100;
        n = 0; last = -1000; seen = 1'b0;
        while (!(m_idle() && mq.size() == 0) && n < 2400) begin
            @(negedge clk);
            n++;
            if (tx_start) begin
                gap = n - last;
                if (seen) chk("burst_gap", 32'(gap >= 100), 32'd1);
                seen = 1'b1;
                last = n;
            end
        end
        chk("burst_drain", 32'(mq.size() == 0), 32'd1);

        // overflow: 8'hFF must be dropped and never sent
        bmode = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) put(8'($urandom));
        put(8'hFF);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_cnt",   32'(count),    32'd16);
        @(negedge clk);
        chk("ovf_once",  32'(overflow), 32'd0);
        bmode = 3; frame_len = 12;
        wait_idle("ovf_drain", 800);

        // count held at 15 with a write on every pop edge, across many wraps
        bmode = 1;
        @(negedge clk);
        for (int i = 0; i < 15; i++) put(8'($urandom));
        bmode = 0;
        pops = 0; n = 0;
        while (pops < 40 && n < 600) begin
            @(negedge clk);
            n++;
            if (m_idle() && mq.size() > 0 && !tx_busy) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                pops++;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("wrap_pops", 32'(pops), 32'd40);
        chk("wrap_cnt",  32'(count), 32'd15);
        bmode = 3; frame_len = 4;
        wait_idle("wrap_drain", 600);

        // acknowledge timeout
        bmode = 0;
        @(negedge clk);
        put(8'h3C);
        n = 0;
        while (!tx_start && n < 10) begin @(negedge clk); n++; end
        chk("tmo_launch", 32'(tx_start), 32'd1);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ack_err) break;
        end
        chk("tmo_lat", 32'(n), 32'(ACK_TIMEOUT + 1));
        bmode = 3; frame_len = 8;
        put(8'h5A);
        wait_idle("tmo_next", 100);

        // random traffic
        bmode = 2;
        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_data = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        bmode = 3; frame_len = 5;
        wait_idle("rand_drain", 1000);

        // reset during a frame with 5 bytes queued
        bmode = 3; frame_len = 100;
        for (int i = 0; i < 6; i++) put(8'h40 + 8'(i));
        repeat (10) @(negedge clk);
        chk("rst_pre_cnt", 32'(count), 32'd5);
        bmode = 0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt",   32'(count),    32'd0);
        chk("arst_empty", 32'(empty),    32'd1);
        chk("arst_full",  32'(full),     32'd0);
        chk("arst_start", 32'(tx_start), 32'd0);
        chk("arst_data",  32'(tx_data),  32'd0);
        chk("arst_ovf",   32'(overflow), 32'd0);
        chk("arst_aerr",  32'(ack_err),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        chk("rst_no_start", 32'(starts), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
